// File: rtl/alu_sequencer.sv
// alu_sequencer
// Steps the 8-bit ALU through one register-level arithmetic/logic instruction.
// The source operand is first moved over WBUS into TMP (skipped for unary ops).
// The ALU result is then moved over WBUS into the destination register.
// The registered {sign,zero} flags are kept here.
// Every control output is a flop, so WBUS enables never glitch.
// An asynchronous reset clears the enables at once, without waiting for a clock edge.

module alu_sequencer #(
    parameter logic [1:0] FLAG_RST = 2'b00,
    parameter bit         IMM_EN   = 1'b1
) (
    input  logic       CLK,
    input  logic       CLR_bar,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [1:0] src,
    input  logic [1:0] dst,
    input  logic [1:0] alu_flags,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [3:0] Sel,
    output logic       Eu,
    output logic       Eb,
    output logic       Ec,
    output logic       Em,
    output logic       Lt,
    output logic       La,
    output logic       Lb,
    output logic       Lc,
    output logic [1:0] flags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_EXEC = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t     r_state;
    logic [1:0] r_dst;
    logic       r_flagUpd;

    logic       w_opKnown;
    logic       w_isUnary;
    logic       w_srcLegal;
    logic       w_illegal;
    logic [2:0] w_srcEnables;
    logic [2:0] w_dstLoads;
    logic [2:0] w_capDstLoads;

    // One-hot {La,Lb,Lc} for a destination code; code 11 updates only the flags.
    function automatic logic [2:0] decodeDst(input logic [1:0] d);
        logic [2:0] loads;
        case (d)
            2'b00:   loads = 3'b100;
            2'b01:   loads = 3'b010;
            2'b10:   loads = 3'b001;
            default: loads = 3'b000;
        endcase
        return loads;
    endfunction

    // One-hot {Eb,Ec,Em} for a source code; the reserved code drives nothing.
    function automatic logic [2:0] decodeSrc(input logic [1:0] s);
        logic [2:0] enables;
        case (s)
            2'b00:   enables = 3'b100;
            2'b01:   enables = 3'b010;
            2'b10:   enables = 3'b001;
            default: enables = 3'b000;
        endcase
        return enables;
    endfunction

    // Classify the requested op code: known or not, and unary (no TMP load) or not.
    always_comb begin
        w_opKnown = 1'b0;
        w_isUnary = 1'b0;
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110: w_opKnown = 1'b1;
            4'b1101, 4'b1110, 4'b1111: begin
                w_opKnown = 1'b1;
                w_isUnary = 1'b1;
            end
            default: w_opKnown = 1'b0;
        endcase
    end

    // The immediate path is legal only when the Em path is built in.
    always_comb begin
        w_srcLegal = 1'b0;
        case (src)
            2'b00, 2'b01: w_srcLegal = 1'b1;
            2'b10:        w_srcLegal = IMM_EN;
            default:      w_srcLegal = 1'b0;
        endcase
    end

    assign w_illegal     = !w_opKnown || (!w_isUnary && !w_srcLegal);
    assign w_srcEnables  = decodeSrc(src);
    assign w_dstLoads    = decodeDst(dst);
    assign w_capDstLoads = decodeDst(r_dst);

    // Sequencer FSM: each output is registered with the value it must carry in the next state.
    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            r_state   <= S_IDLE;
            r_dst     <= 2'b11;
            r_flagUpd <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            Sel       <= 4'b0000;
            flags     <= FLAG_RST;
            Eu        <= 1'b0;
            Eb        <= 1'b0;
            Ec        <= 1'b0;
            Em        <= 1'b0;
            Lt        <= 1'b0;
            La        <= 1'b0;
            Lb        <= 1'b0;
            Lc        <= 1'b0;
        end else begin
            ready <= 1'b0;
            done  <= 1'b0;
            Eu    <= 1'b0;
            Eb    <= 1'b0;
            Ec    <= 1'b0;
            Em    <= 1'b0;
            Lt    <= 1'b0;
            La    <= 1'b0;
            Lb    <= 1'b0;
            Lc    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        Sel       <= op;
                        r_dst     <= dst;
                        r_flagUpd <= ~op[3];
                        if (w_illegal) begin
                            err     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_isUnary) begin
                            err          <= 1'b0;
                            Eu           <= 1'b1;
                            {La, Lb, Lc} <= w_dstLoads;
                            r_state      <= S_EXEC;
                        end else begin
                            err          <= 1'b0;
                            {Eb, Ec, Em} <= w_srcEnables;
                            Lt           <= 1'b1;
                            r_state      <= S_LOAD;
                        end
                    end else begin
                        ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    Eu           <= 1'b1;
                    {La, Lb, Lc} <= w_capDstLoads;
                    r_state      <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_flagUpd) begin
                        flags <= alu_flags;
                    end
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Directed scenarios with literal expectations, followed by randomized traffic.
// The random traffic includes occasional asynchronous resets.
// A transaction-level model predicts the outputs for every cycle.

module tb_alu_sequencer;

    localparam logic [1:0] FLAG_RST = 2'b00;
    localparam bit         IMM_EN   = 1'b1;

    logic       CLK = 1'b0;
    logic       CLR_bar = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op = 4'b0000;
    logic [1:0] src = 2'b00;
    logic [1:0] dst = 2'b00;
    logic [1:0] alu_flags = 2'b00;
    logic       ready;
    logic       done;
    logic       err;
    logic [3:0] Sel;
    logic       Eu;
    logic       Eb;
    logic       Ec;
    logic       Em;
    logic       Lt;
    logic       La;
    logic       Lb;
    logic       Lc;
    logic [1:0] flags;

    int checks = 0;
    int errors = 0;
    logic checkOn = 1'b0;

    alu_sequencer #(.FLAG_RST(FLAG_RST), .IMM_EN(IMM_EN)) dut (
        .CLK(CLK), .CLR_bar(CLR_bar), .start(start), .op(op), .src(src), .dst(dst),
        .alu_flags(alu_flags), .ready(ready), .done(done), .err(err), .Sel(Sel),
        .Eu(Eu), .Eb(Eb), .Ec(Ec), .Em(Em), .Lt(Lt), .La(La), .Lb(Lb), .Lc(Lc),
        .flags(flags)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: each accepted op becomes a list of per-cycle output vectors.
    // Vector bits: {ready,done,Eu,Eb,Ec,Em,Lt,La,Lb,Lc}; an empty list means idle.
    typedef struct packed {
        logic [9:0] outs;
        logic       flagUpd;
    } step_t;

    step_t      plan[$];
    logic [1:0] mFlags = FLAG_RST;
    logic [3:0] mSel = 4'b0000;
    logic       mErr = 1'b0;

    function automatic logic [9:0] loadBits(input logic [1:0] d);
        if (d == 2'd0) return 10'b00_0000_0100;
        if (d == 2'd1) return 10'b00_0000_0010;
        if (d == 2'd2) return 10'b00_0000_0001;
        return 10'b0;
    endfunction

    function automatic logic [9:0] srcBits(input logic [1:0] s);
        if (s == 2'd0) return 10'b00_0100_0000;
        if (s == 2'd1) return 10'b00_0010_0000;
        if (s == 2'd2) return 10'b00_0001_0000;
        return 10'b0;
    endfunction

    task automatic acceptOp(input logic [3:0] o, input logic [1:0] s, input logic [1:0] d);
        bit unary;
        bit known;
        bit illegal;
        unary   = (o >= 4'd13);
        known   = (o <= 4'd6) || unary;
        illegal = !known || (!unary && (s == 2'd3 || (s == 2'd2 && !IMM_EN)));
        mSel = o;
        mErr = illegal;
        if (illegal) begin
            plan.push_back('{outs: 10'b01_0000_0000, flagUpd: 1'b0});
        end else begin
            if (!unary) plan.push_back('{outs: srcBits(s) | 10'b00_0000_1000, flagUpd: 1'b0});
            plan.push_back('{outs: 10'b00_1000_0000 | loadBits(d), flagUpd: (o < 4'd8)});
            plan.push_back('{outs: 10'b01_0000_0000, flagUpd: 1'b0});
        end
    endtask

    // Model advance: on each clock edge or reset, consume one planned cycle or accept a new op.
    initial begin
        step_t cur;
        forever begin
            @(posedge CLK or negedge CLR_bar);
            if (!CLR_bar) begin
                plan.delete();
                mFlags = FLAG_RST;
                mSel   = 4'b0000;
                mErr   = 1'b0;
            end else if (plan.size() != 0) begin
                cur = plan.pop_front();
                if (cur.flagUpd) mFlags = alu_flags;
            end else if (start) begin
                acceptOp(op, src, dst);
            end
        end
    end

    // Per-cycle compare against the model, plus WBUS exclusivity, sampled on the falling edge.
    always @(negedge CLK) begin
        logic [9:0] expOuts;
        logic       busOk;
        if (checkOn && CLR_bar) begin
            expOuts = (plan.size() != 0) ? plan[0].outs : 10'b10_0000_0000;
            checkOutput("cycleOutputs", {6'b0, ready, done, Eu, Eb, Ec, Em, Lt, La, Lb, Lc}, {6'b0, expOuts});
            checkOutput("flags", {14'b0, flags}, {14'b0, mFlags});
            checkOutput("selErr", {11'b0, Sel, err}, {11'b0, mSel, mErr});
            busOk = ($countones({Eu, Eb, Ec, Em}) <= 1) && !(Eu && Lt);
            checkOutput("busExclusive", {15'b0, busOk}, 16'h0001);
        end
    end

    task automatic applyStimulus(input logic s, input logic [3:0] o, input logic [1:0] sr,
                                 input logic [1:0] d, input logic [1:0] af);
        @(negedge CLK);
        start     = s;
        op        = o;
        src       = sr;
        dst       = d;
        alu_flags = af;
    endtask

    // Request one op, then return 1 time unit into the first cycle after acceptance.
    task automatic issueOne(input logic [3:0] o, input logic [1:0] sr, input logic [1:0] d, input logic [1:0] af);
        applyStimulus(1'b1, o, sr, d, af);
        @(negedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic nextCycle();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        int doneCount;

        // Reset state while CLR_bar is held low.
        #7;
        checkOutput("resetState", {3'b0, ready, done, err, Sel, Eu, Eb, Ec, Em, Lt, La, Lb, Lc},
                    {3'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 8'b0});
        checkOutput("resetFlags", {14'b0, flags}, {14'b0, FLAG_RST});
        @(negedge CLK);
        #2 CLR_bar = 1'b1;
        checkOn = 1'b1;

        // ADD B->A with alu_flags=01.
        issueOne(4'b0000, 2'b00, 2'b00, 2'b01);
        checkOutput("addC1", {9'b0, Eb, Lt, Eu, Sel}, {9'b0, 1'b1, 1'b1, 1'b0, 4'b0000});
        nextCycle();
        checkOutput("addC2", {12'b0, Eu, La, Lt, Eb}, 16'b1100);
        nextCycle();
        checkOutput("addC3", {13'b0, done, flags}, {13'b0, 1'b1, 2'b01});
        nextCycle();
        checkOutput("addC4", {15'b0, ready}, 16'h0001);

        // SUB immediate, flags only.
        issueOne(4'b0001, 2'b10, 2'b11, 2'b10);
        checkOutput("subC1", {13'b0, Em, Lt, Eu}, 16'b110);
        nextCycle();
        checkOutput("subC2", {12'b0, Eu, La, Lb, Lc}, 16'b1000);
        nextCycle();
        checkOutput("subC3", {13'b0, done, flags}, {13'b0, 1'b1, 2'b10});

        // RAR into A: unary op, flags hold.
        issueOne(4'b1111, 2'b00, 2'b00, 2'b01);
        checkOutput("rarC1", {9'b0, Eu, La, Lt, Sel}, {9'b0, 1'b1, 1'b1, 1'b0, 4'b1111});
        nextCycle();
        checkOutput("rarC2", {13'b0, done, flags}, {13'b0, 1'b1, 2'b10});

        // Illegal op, then a legal INC C->C.
        issueOne(4'b1000, 2'b00, 2'b00, 2'b01);
        checkOutput("illegalC1", {4'b0, done, err, Eu, Eb, Ec, Em, Lt, La, Lb, Lc, flags},
                    {4'b0, 1'b1, 1'b1, 8'b0, 2'b10});
        issueOne(4'b0101, 2'b01, 2'b10, 2'b11);
        checkOutput("incC1", {13'b0, err, Ec, Lt}, 16'b011);
        nextCycle();
        checkOutput("incC2", {12'b0, Eu, Lc, La, Lb}, 16'b1100);
        nextCycle();
        checkOutput("incC3", {14'b0, flags}, 16'b11);

        // Asynchronous reset in the middle of EXEC.
        issueOne(4'b0001, 2'b00, 2'b00, 2'b01);
        nextCycle();
        checkOutput("preResetLa", {15'b0, La}, 16'h0001);
        CLR_bar = 1'b0;
        #1;
        checkOutput("asyncReset", {4'b0, La, Eu, ready, done, err, Sel, flags, 1'b0},
                    {4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, FLAG_RST, 1'b0});
        #1 CLR_bar = 1'b1;

        // start held for 10 cycles: ops complete back-to-back every 4 cycles.
        applyStimulus(1'b1, 4'b0000, 2'b00, 2'b00, 2'b01);
        doneCount = 0;
        for (int i = 1; i <= 14; i++) begin
            nextCycle();
            if (done) doneCount++;
            if (i == 10) start = 1'b0;
        end
        checkOutput("heldStartDones", doneCount[15:0], 16'd3);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 800; n++) begin
            applyStimulus(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 99) == 0) begin
                #2 CLR_bar = 1'b0;
                #1 CLR_bar = 1'b1;
            end
        end

        nextCycle();
        checkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
